// File: rtl/seq_rec_pkg.sv
// Shared types and default parameters for the run-length recognizer scheduler.
package seq_rec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_WIN_LEN = 16;
    localparam int DEF_RUN_LEN = 3;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/run_len_rec.sv
// Run-length recognizer: flags each sample that completes or extends a run of
// at least RUN_LEN consecutive 1s. The hit output is Mealy on the incoming bit.
module run_len_rec #(
    parameter int RUN_LEN = seq_rec_pkg::DEF_RUN_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    localparam int RW = $clog2(RUN_LEN);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN - 1);

    logic [RW-1:0] run;
    logic          one;

    // Only a solid 1 extends the run; 0, X and Z all break it.
    assign one = (bit_in == 1'b1);
    assign hit = en && (run == RUN_MAX) && one;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            run <= '0;
        end else if (en) begin
            if (one) begin
                if (run != RUN_MAX)
                    run <= run + 1'b1;
            end else begin
                run <= '0;
            end
        end
    end

endmodule

// File: rtl/seq_rec_scheduler.sv
// Round-robin scheduler sharing one run-length recognizer among N_CH serial
// channels; each grant covers WIN_LEN samples and reports its hit count.
module seq_rec_scheduler
    import seq_rec_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH-1:0]         d_in,
    output logic [N_CH-1:0]         grant,
    output logic                    rec_en,
    output logic                    rec_hit,
    output logic                    done,
    output logic [$clog2(N_CH)-1:0] done_ch,
    output logic [CNT_W-1:0]        hit_count
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int BC_W  = $clog2(WIN_LEN);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(N_CH - 1);

    state_t            state, state_next;
    logic [IDX_W-1:0]  rr_ptr, gnt_idx, pick_idx, cand;
    logic              pick_vld, start, mux_bit, last_sample;
    logic [BC_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]  hit_cnt, hit_cnt_next;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % N_CH);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign start       = (state == IDLE) && pick_vld;
    assign mux_bit     = d_in[gnt_idx];
    assign rec_en      = (state == RUN);
    assign done        = (state == REPORT);
    assign last_sample = rec_en && (bit_cnt == LAST_BIT);

    always_comb begin
        hit_cnt_next = hit_cnt;
        if (rec_hit && (hit_cnt != '1))
            hit_cnt_next = hit_cnt + 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_sample) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            bit_cnt   <= '0;
            hit_cnt   <= '0;
            hit_count <= '0;
            done_ch   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        grant   <= N_CH'(1) << pick_idx;
                        gnt_idx <= pick_idx;
                        bit_cnt <= '0;
                        hit_cnt <= '0;
                    end
                end
                RUN: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    hit_cnt <= hit_cnt_next;
                    // Report includes a hit landing on the final sample.
                    if (last_sample) begin
                        hit_count <= hit_cnt_next;
                        done_ch   <= gnt_idx;
                    end
                end
                REPORT: begin
                    grant  <= '0;
                    rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
                end
                default: grant <= '0;
            endcase
        end
    end

    run_len_rec #(
        .RUN_LEN(RUN_LEN)
    ) u_rec (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (rec_en),
        .bit_in(mux_bit),
        .hit   (rec_hit)
    );

endmodule
